// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
//   Bundles the operand handshake and the result bus of serial_adder.
//   master : operand source / result consumer (drives start, a, b, cin)
//   slave  : the serial adder (drives busy, done, sum, cout[, ovf])
//
//   Signals:
//     start  request, sampled by the adder only while idle
//     a, b   WIDTH-bit operands, cin carry-in (captured on acceptance)
//     busy   adder is shifting or presenting its result
//     done   one-cycle pulse, sum/cout (and ovf) valid
//     sum    WIDTH-bit registered result, cout registered carry-out
//     ovf    two's-complement overflow, present only with SERIAL_ADD_OVF_EN
// ---------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. One full-adder slice and a registered carry
//   process one bit pair per clock, LSB first; the sum bits are collected in
//   a shift register and published in parallel together with cout and a
//   one-cycle done pulse. An operation occupies WIDTH+2 cycles
//   (IDLE accept, WIDTH x SHIFT, DONE).
//
//   Ports:
//     clk    clock, all state updates on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    serial_adder_if.slave: start/a/b/cin in, busy/done/sum/cout out
//
//   Optional feature macro: SERIAL_ADD_OVF_EN
//     When defined, bus.ovf reports two's-complement overflow
//     (carry into MSB XOR carry out of MSB), registered with sum/cout.
//     When undefined, no ovf port and no MSB-carry capture exist.
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-adder slice on the current LSB pair and the registered carry.
  logic fa_s, fa_c;
  assign fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign fa_c = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

  // NOTE: every _d gets its hold value first so no path through the case
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the completed word; carry_q is the carry into
          // the MSB and fa_c the carry out of it.
          sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
          cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_c;
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // The datapath registers are reset as well, because an aborted operation
  // must leave no stale operand, carry or count behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
